// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM states, response entry layout and the fault check.
package cpu_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_RUN,
        S_LOAD
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [31:0]       addr;
        logic              fault;
    } fetch_rsp_t;

    // Misaligned PC or a word index beyond the memory depth.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_bram.sv
// Single-port synchronous-read/synchronous-write instruction RAM; no reset so it maps to block RAM.
module imem_bram #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: credit-limited request acceptance, 1-cycle RAM read, 2-entry
// in-order response buffer with flush, and a boot-time program-load mode.
module imem_fetch_responder
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 14,
    parameter logic [WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [31:0]       rsp_addr,
    output logic              rsp_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_busy
);

    fetch_state_e state_q, state_d;
    logic         ready_en_q;

    logic         inflight_q;
    logic [31:0]  inflight_addr_q;
    logic         inflight_fault_q;

    fetch_rsp_t   buf_q [2];
    logic [1:0]   wr_ptr_q, rd_ptr_q;

    logic [1:0]   count;
    logic [1:0]   outstanding;
    logic         req_fire;
    logic         rsp_fire;
    logic         req_is_fault;
    logic         push;
    logic         load_wr;
    fetch_rsp_t   head;
    fetch_rsp_t   push_entry;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    imem_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_imem_bram (
        .clk_i   (clock),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (load_data),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        count        = wr_ptr_q - rd_ptr_q;
        outstanding  = count + {1'b0, inflight_q};
        head         = buf_q[rd_ptr_q[0]];
        rsp_valid    = (count != 2'd0);
        rsp_instr    = head.instr;
        rsp_addr     = head.addr;
        rsp_fault    = head.fault;
        rsp_fire     = rsp_valid && rsp_ready;
        load_busy    = (state_q == S_LOAD);
        req_is_fault = addr_fault(req_addr, ADDR_W);
        // A response leaving this cycle frees its credit immediately, giving 1 req/cycle.
        req_ready    = ready_en_q && (state_q == S_RUN) && !load_en &&
                       ((outstanding - {1'b0, rsp_fire}) < 2'd2);
        req_fire     = req_valid && req_ready;
        // The word read last cycle is dropped if a flush lands on its arrival edge.
        push         = inflight_q && !flush;
        push_entry   = '{instr: (inflight_fault_q ? NOP_INSTR : mem_rdata),
                         addr:  inflight_addr_q,
                         fault: inflight_fault_q};

        // The drained cycle that enters S_LOAD already commits the first word.
        load_wr  = load_en && ((state_q == S_LOAD) || (outstanding == 2'd0));
        mem_en   = load_wr || (req_fire && !req_is_fault);
        mem_we   = load_wr;
        mem_addr = load_wr ? load_addr : req_addr[ADDR_W+1:2];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:  if (load_en && (outstanding == 2'd0)) state_d = S_LOAD;
            S_LOAD: if (!load_en) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_RUN;
            ready_en_q       <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_addr_q  <= 32'd0;
            inflight_fault_q <= 1'b0;
            wr_ptr_q         <= 2'd0;
            rd_ptr_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            inflight_q <= req_fire;
            if (req_fire) begin
                inflight_addr_q  <= req_addr;
                inflight_fault_q <= req_is_fault;
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    buf_q[wr_ptr_q[0]] <= push_entry;
                    wr_ptr_q           <= wr_ptr_q + 2'd1;
                end
                if (rsp_fire) begin
                    rd_ptr_q <= rd_ptr_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: per-cycle vector table plus load, flush and reset
// sequences with hand-computed expectations.
module tb_imem_fetch_responder;

    localparam int unsigned ADDR_W = 14;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic [31:0]       rsp_addr;
    logic              rsp_fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        fl;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    imem_fetch_responder #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_busy (load_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic add(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic er, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ea, input logic ef);
        vecs.push_back('{rv, ra, rr, fl, er, ev, ei, ea, ef});
    endtask

    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic load_begin(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        wait_busy("load_enter");
    endtask

    task automatic load_next(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        load_addr = a;
        load_data = d;
        tick();
    endtask

    task automatic load_end();
        load_en = 1'b0;
        tick();
        chk("load_busy_exit", {31'd0, load_busy}, 32'd0);
    endtask

    task automatic fetch_one(input logic [31:0] a, input logic [31:0] ei, input logic ef);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!ok) begin
            timeout("fetch_accept");
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                chk("fetch_instr", rsp_instr, ei);
                chk("fetch_addr", rsp_addr, a);
                chk("fetch_fault", {31'd0, rsp_fault}, {31'd0, ef});
                tick();
                break;
            end
            tick();
        end
        if (!ok) timeout("fetch_rsp");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'd0;

        // Reset values while held, then req_ready rises on the first edge after release.
        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_addr", rsp_addr, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_load_busy", {31'd0, load_busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_req_ready_pre", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rel_req_ready_post", {31'd0, req_ready}, 32'd1);

        load_begin(14'd0, 32'h0050_0093);
        chk("load_busy_in", {31'd0, load_busy}, 32'd1);
        load_next(14'd1, 32'h0010_0113);
        load_next(14'd2, 32'hdead_beef);
        load_next(14'd3, 32'h1234_5678);
        load_next(14'h10, 32'hcafe_0001);
        load_next(14'h3fff, 32'ha5a5_a5a5);
        load_end();

        // Back-to-back fetch, rsp_ready=1.
        add(1, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h4, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'h0050_0093, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'h0010_0113, 32'h4, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Backpressure: third request held off until a response drains.
        add(1, 32'h8, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'hc, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h0, 0, 0, 0, 1, 32'hdead_beef, 32'h8, 0);
        add(1, 32'h0, 0, 0, 0, 1, 32'hdead_beef, 32'h8, 0);
        add(1, 32'h0, 1, 0, 1, 1, 32'hdead_beef, 32'h8, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'h1234_5678, 32'hc, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'h0050_0093, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Faults interleaved with the last valid word.
        add(1, 32'h6, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h0001_0000, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h0000_fffc, 1, 0, 1, 1, 32'h0000_0013, 32'h6, 1);
        add(0, 32'h0, 1, 0, 1, 1, 32'h0000_0013, 32'h0001_0000, 1);
        add(0, 32'h0, 1, 0, 1, 1, 32'ha5a5_a5a5, 32'h0000_fffc, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Flush with a buffered word, an inflight word and a branch-target request.
        add(1, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h4, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'h40, 1, 1, 1, 1, 32'h0050_0093, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'hcafe_0001, 32'h40, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Flush with two buffered words and no credit for a new request.
        add(1, 32'h8, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(1, 32'hc, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 0, 0, 0, 1, 32'hdead_beef, 32'h8, 0);
        add(1, 32'h40, 0, 1, 0, 1, 32'hdead_beef, 32'h8, 0);
        add(1, 32'h40, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 1, 0, 1, 1, 32'hcafe_0001, 32'h40, 0);
        add(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].rv;
            req_addr  = vecs[i].ra;
            rsp_ready = vecs[i].rr;
            flush     = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].exp_ready});
            chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_instr", i), rsp_instr, vecs[i].exp_instr);
                chk($sformatf("v%0d_addr", i), rsp_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_fault", i), {31'd0, rsp_fault}, {31'd0, vecs[i].exp_fault});
            end
            tick();
        end
        req_valid = 1'b0;
        flush     = 1'b0;

        // Load requested while two responses are outstanding waits for the drain.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        load_en   = 1'b1;
        load_addr = 14'd5;
        load_data = 32'h0bad_f00d;
        #1;
        chk("ld_wait_ready", {31'd0, req_ready}, 32'd0);
        chk("ld_wait_busy0", {31'd0, load_busy}, 32'd0);
        tick();
        chk("ld_wait_busy1", {31'd0, load_busy}, 32'd0);
        tick();
        chk("ld_wait_busy2", {31'd0, load_busy}, 32'd0);
        chk("ld_wait_head", rsp_addr, 32'h0);
        rsp_ready = 1'b1;
        wait_busy("load_after_drain");
        chk("ld_drained_valid", {31'd0, rsp_valid}, 32'd0);
        load_next(14'd6, 32'h600d_f00d);
        load_end();
        fetch_one(32'h14, 32'h0bad_f00d, 1'b0);
        fetch_one(32'h18, 32'h600d_f00d, 1'b0);
        fetch_one(32'h4, 32'h0010_0113, 1'b0);

        // Asynchronous reset with two buffered words; memory must survive it.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_addr = 32'hc;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("async_rst_addr", rsp_addr, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rel2_ready_pre", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rel2_ready_post", {31'd0, req_ready}, 32'd1);
        chk("rel2_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rel2_busy", {31'd0, load_busy}, 32'd0);
        fetch_one(32'h0, 32'h0050_0093, 1'b0);
        fetch_one(32'h0000_fffc, 32'ha5a5_a5a5, 1'b0);
        fetch_one(32'h0000_0002, 32'h0000_0013, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
